// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decoded instruction, forwarding sources and the
// registered EX-side outputs that feed the ALU.
interface id_ex_stage_if #(
  parameter int DWIDTH     = 32,
  parameter int ALU_FN_LEN = 4,
  parameter int RADDR      = 5
);
  logic                  id_valid;
  logic                  id_ready;
  logic [DWIDTH-1:0]     id_pc;
  logic [RADDR-1:0]      id_rs1_addr, id_rs2_addr;
  logic [DWIDTH-1:0]     id_rs1_data, id_rs2_data;
  logic                  id_rs1_used, id_rs2_used;
  logic [DWIDTH-1:0]     id_imm;
  logic                  id_op1_sel, id_op2_sel;
  logic [ALU_FN_LEN-1:0] id_alu_fn;
  logic [RADDR-1:0]      id_rd_addr;
  logic                  id_wb_en, id_mem_rd;
  logic                  ex_stall, flush;
  logic                  mem_wb_en;
  logic [RADDR-1:0]      mem_rd_addr;
  logic [DWIDTH-1:0]     mem_fwd_data;
  logic                  wb_en;
  logic [RADDR-1:0]      wb_rd_addr;
  logic [DWIDTH-1:0]     wb_data;
  logic                  ex_valid;
  logic [DWIDTH-1:0]     ex_pc;
  logic [DWIDTH-1:0]     oper1, oper2;
  logic [ALU_FN_LEN-1:0] alu_fn;
  logic [DWIDTH-1:0]     ex_store_data;
  logic [RADDR-1:0]      ex_rd_addr;
  logic                  ex_wb_en, ex_mem_rd;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_rs1_used, id_rs2_used, id_imm, id_op1_sel, id_op2_sel, id_alu_fn,
           id_rd_addr, id_wb_en, id_mem_rd, ex_stall, flush, mem_wb_en,
           mem_rd_addr, mem_fwd_data, wb_en, wb_rd_addr, wb_data,
    input  id_ready, ex_valid, ex_pc, oper1, oper2, alu_fn, ex_store_data,
           ex_rd_addr, ex_wb_en, ex_mem_rd
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_rs1_used, id_rs2_used, id_imm, id_op1_sel, id_op2_sel, id_alu_fn,
           id_rd_addr, id_wb_en, id_mem_rd, ex_stall, flush, mem_wb_en,
           mem_rd_addr, mem_fwd_data, wb_en, wb_rd_addr, wb_data,
    output id_ready, ex_valid, ex_pc, oper1, oper2, alu_fn, ex_store_data,
           ex_rd_addr, ex_wb_en, ex_mem_rd
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion, stall hold and flush; drives the ALU operands directly.
module id_ex_fwd #(
  parameter int DWIDTH = 32,
  parameter int RADDR  = 5
) (
  input  logic [RADDR-1:0]  rs_addr,
  input  logic [DWIDTH-1:0] rs_data,
  input  logic              mem_wb_en,
  input  logic [RADDR-1:0]  mem_rd_addr,
  input  logic [DWIDTH-1:0] mem_fwd_data,
  input  logic              wb_en,
  input  logic [RADDR-1:0]  wb_rd_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [DWIDTH-1:0] fwd
);
  // MEM is younger than WB, so it wins; x0 always reads zero.
  always_comb begin
    fwd = rs_data;
    if (rs_addr == '0)
      fwd = '0;
    else if (mem_wb_en && mem_rd_addr == rs_addr)
      fwd = mem_fwd_data;
    else if (wb_en && wb_rd_addr == rs_addr)
      fwd = wb_data;
  end
endmodule

module id_ex_stage #(
  parameter int DWIDTH       = 32,
  parameter int ALU_FN_LEN   = 4,
  parameter int RADDR        = 5,
  parameter int ALU_ADD_CODE = 0
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  localparam int NOPS = 2;
  localparam logic [ALU_FN_LEN-1:0] FN_ADD = ALU_FN_LEN'(ALU_ADD_CODE);

  logic [NOPS-1:0][RADDR-1:0]  id_rs_addr, rs_addr_q;
  logic [NOPS-1:0][DWIDTH-1:0] id_rs_data, rs_data_q, wt_data, fwd;
  logic [NOPS-1:0]             id_rs_used, rs_hit;

  logic                  valid_q, wb_en_q, mem_rd_q, op1_sel_q, op2_sel_q;
  logic [DWIDTH-1:0]     pc_q, imm_q;
  logic [ALU_FN_LEN-1:0] fn_q;
  logic [RADDR-1:0]      rd_q;
  logic                  load_use, bubble;

  assign id_rs_addr = {bus.id_rs2_addr, bus.id_rs1_addr};
  assign id_rs_data = {bus.id_rs2_data, bus.id_rs1_data};
  assign id_rs_used = {bus.id_rs2_used, bus.id_rs1_used};

  generate
    for (genvar g = 0; g < NOPS; g++) begin : g_op
      id_ex_fwd #(.DWIDTH(DWIDTH), .RADDR(RADDR)) u_fwd (
        .rs_addr     (rs_addr_q[g]),
        .rs_data     (rs_data_q[g]),
        .mem_wb_en   (bus.mem_wb_en),
        .mem_rd_addr (bus.mem_rd_addr),
        .mem_fwd_data(bus.mem_fwd_data),
        .wb_en       (bus.wb_en),
        .wb_rd_addr  (bus.wb_rd_addr),
        .wb_data     (bus.wb_data),
        .fwd         (fwd[g])
      );
      // Register file write and read in the same cycle: take the write value.
      assign wt_data[g] = (bus.wb_en && bus.wb_rd_addr != '0 &&
                           bus.wb_rd_addr == id_rs_addr[g]) ? bus.wb_data : id_rs_data[g];
      assign rs_hit[g]  = id_rs_used[g] && (id_rs_addr[g] == rd_q);
    end
  endgenerate

  assign load_use     = valid_q && mem_rd_q && (rd_q != '0) && (|rs_hit);
  assign bus.id_ready = !bus.ex_stall && (bus.flush || !load_use);
  assign bubble       = bus.flush || load_use || !bus.id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      fn_q      <= FN_ADD;
      op1_sel_q <= 1'b0;
      op2_sel_q <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rs_addr_q <= '0;
      rs_data_q <= '0;
    end else if (bus.ex_stall) begin
      // Capture forwarded values so a producer retiring mid-stall is kept.
      rs_data_q <= fwd;
    end else if (bubble) begin
      valid_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      fn_q     <= FN_ADD;
    end else begin
      valid_q   <= 1'b1;
      wb_en_q   <= bus.id_wb_en;
      mem_rd_q  <= bus.id_mem_rd;
      fn_q      <= bus.id_alu_fn;
      op1_sel_q <= bus.id_op1_sel;
      op2_sel_q <= bus.id_op2_sel;
      pc_q      <= bus.id_pc;
      imm_q     <= bus.id_imm;
      rd_q      <= bus.id_rd_addr;
      rs_addr_q <= id_rs_addr;
      rs_data_q <= wt_data;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.oper1         = op1_sel_q ? pc_q : fwd[0];
  assign bus.oper2         = op2_sel_q ? imm_q : fwd[1];
  assign bus.alu_fn        = fn_q;
  assign bus.ex_store_data = fwd[1];
  assign bus.ex_rd_addr    = rd_q;
  assign bus.ex_wb_en      = valid_q & wb_en_q;
  assign bus.ex_mem_rd     = valid_q & mem_rd_q;
endmodule
